ahblite_1ton: RTL
=================

AHBLITE_1TON -- requirements
Module: ahblite1ton

Interface
REQ-001 Parameter NUM_SLV, default 4: number of slave ports; legal range 2..8.
REQ-002 Parameter SLV_BASE, default {32'h6000_0000,32'h4000_0000,32'h2000_0000,32'h0000_0000}: per-slave base addresses, NUM_SLV*32 bits, slave i in bits [32i+31:32i].
REQ-003 Parameter SLV_MASK, default {4{32'hE000_0000}}: per-slave compare masks, same packing as SLV_BASE.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 fm_hsel, fm_hready, fm_hwrite  input  1 each  master address-phase controls.
REQ-007 fm_haddr, fm_hwdata  input  32 each  master address and write data.
REQ-008 fm_htrans input 2; fm_hsize, fm_hburst input 3; fm_hprot input 4  master controls.
REQ-009 tm_hready, tm_hresp  output  1 each; tm_hrdata  output  32  muxed response to the master.
REQ-010 ts_hsel, ts_hready  output  NUM_SLV  per-slave select and global HREADY copy.
REQ-011 ts_haddr, ts_hwdata (32), ts_htrans (2), ts_hwrite (1), ts_hsize, ts_hburst (3), ts_hprot (4)  output  shared broadcast of the master signals.
REQ-012 fs_hready, fs_hresp  input  NUM_SLV; fs_hrdata  input  NUM_SLV*32  per-slave responses.
REQ-013 err_clr  input  1  single-cycle clear of the error capture.
REQ-014 err_valid output 1; err_addr output 32; err_write output 1; err_src output 4 (value NUM_SLV = default slave)  sticky error capture.

Function
REQ-015 Hit i SHALL be (((fm_haddr^base_i)&mask_i)==0)&fm_hsel; on overlapping hits the lowest index wins; ts_hsel SHALL be one-hot or zero.
REQ-016 When fm_hsel=1 and no slave hits, the transfer SHALL target the internal default slave.
REQ-017 Address/control outputs SHALL be combinational copies of the master inputs, with zero latency.
REQ-018 The data-phase owner register SHALL load {slave index, htrans[1]} only when tm_hready=1.
REQ-019 tm_hready/tm_hresp/tm_hrdata SHALL be taken from the data-phase owner, and ts_hready[*] SHALL equal tm_hready.
REQ-020 With no owner (IDLE/BUSY, or hsel=0), the outputs SHALL be tm_hready=1, tm_hresp=0, tm_hrdata=0.
REQ-021 Default slave FSM states: IDLE, ERR1, ERR2.
- IDLE->ERR1 when a NONSEQ/SEQ transfer to the default slave is accepted (tm_hready=1).
- ERR1: hready=0, hresp=1, always ->ERR2.
- ERR2: hready=1, hresp=1; ->ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle, else ->IDLE.
REQ-022 IDLE/BUSY transfers to unmapped addresses SHALL return zero-wait OKAY.
REQ-023 The default slave SHALL drive hrdata=0.
REQ-024 Error capture condition: first cycle of an ERROR response (hresp=1, hready=0) while err_valid=0.
REQ-025 On capture, the block SHALL latch the data-phase address, write flag and owner index, and set err_valid.
REQ-026 Later errors SHALL NOT overwrite the capture until err_clr.
REQ-027 err_clr SHALL clear err_valid next cycle; when err_clr and a capture event coincide, the new capture SHALL win.
REQ-028 Slave ERROR responses SHALL pass through unmodified, and SHALL be captured per REQ-024..027.

Reset
REQ-029 While rst_n=0 at a clock edge: owner register cleared (no owner), FSM=IDLE, err_valid=0, err_addr=0, err_write=0, err_src=0.
REQ-030 Post-reset outputs: tm_hready=1, tm_hresp=0, tm_hrdata=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer, with no residual ERR state.

Structure
REQ-032 Shared package ahb_pkg SHALL hold the HTRANS and HRESP encodings, the default-slave FSM state encoding, and the AHB width constants.
REQ-033 The default slave and its FSM SHALL be the sub-module ahb_default_slv; decode, mux and error capture stay in ahblite1ton.

Verification
REQ-034 NONSEQ read 0x2000_0010, fs_hrdata[1]=0xA5A5_A5A5, fs_hready[1]=1 -> ts_hsel=4'b0010; next cycle tm_hrdata=0xA5A5_A5A5, tm_hready=1.
REQ-035 Slave 0 holds fs_hready[0]=0 for 3 cycles -> tm_hready=0 for exactly 3 cycles; a pipelined address to slave 2 during the stall is decoded but the owner does not change until tm_hready=1.
REQ-036 NONSEQ write 0xE000_0000 (unmapped) -> tm_hready=0/hresp=1, then 1/1; err_valid=1, err_addr=0xE000_0000, err_write=1, err_src=4.
REQ-037 Back-to-back unmapped NONSEQs -> two consecutive 2-cycle ERROR responses; err_addr keeps the first address.
REQ-038 err_clr pulsed on the same cycle as a new slave-3 ERROR -> err_valid stays 1, err_src=3.
REQ-039 rst_n=0 asserted in ERR1 -> next cycle FSM=IDLE, tm_hready=1, tm_hresp=0, err_valid=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, widths and the default-slave state type.
package ahb_pkg;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SRC_W = 4;

  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_e;
  typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} hresp_e;
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} dslv_state_e;

  typedef struct packed {
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
  } ahb_rsp_t;

  // NONSEQ and SEQ both carry htrans[1]=1.
  function automatic logic trans_active(logic [1:0] t);
    return t[1];
  endfunction
endpackage

// File: rtl/ahblite_1ton_if.sv
// Master-side and slave-side bus bundle of the 1-to-N AHB-Lite decoder.
interface ahblite_1ton_if #(parameter int NUM_SLV = 4);
  import ahb_pkg::*;
  logic                        fm_hsel, fm_hready, fm_hwrite;
  logic [AW-1:0]               fm_haddr;
  logic [DW-1:0]               fm_hwdata;
  logic [1:0]                  fm_htrans;
  logic [2:0]                  fm_hsize, fm_hburst;
  logic [3:0]                  fm_hprot;
  logic                        tm_hready, tm_hresp;
  logic [DW-1:0]               tm_hrdata;
  logic [NUM_SLV-1:0]          ts_hsel, ts_hready;
  logic [AW-1:0]               ts_haddr;
  logic [DW-1:0]               ts_hwdata;
  logic [1:0]                  ts_htrans;
  logic                        ts_hwrite;
  logic [2:0]                  ts_hsize, ts_hburst;
  logic [3:0]                  ts_hprot;
  logic [NUM_SLV-1:0]          fs_hready, fs_hresp;
  logic [NUM_SLV-1:0][DW-1:0]  fs_hrdata;

  // Environment view: drives master requests and slave responses.
  modport master (
    output fm_hsel, fm_hready, fm_hwrite, fm_haddr, fm_hwdata, fm_htrans, fm_hsize, fm_hburst, fm_hprot,
    output fs_hready, fs_hresp, fs_hrdata,
    input  tm_hready, tm_hresp, tm_hrdata,
    input  ts_hsel, ts_hready, ts_haddr, ts_hwdata, ts_htrans, ts_hwrite, ts_hsize, ts_hburst, ts_hprot
  );
  // Decoder view.
  modport slave (
    input  fm_hsel, fm_hready, fm_hwrite, fm_haddr, fm_hwdata, fm_htrans, fm_hsize, fm_hburst, fm_hprot,
    input  fs_hready, fs_hresp, fs_hrdata,
    output tm_hready, tm_hresp, tm_hrdata,
    output ts_hsel, ts_hready, ts_haddr, ts_hwdata, ts_htrans, ts_hwrite, ts_hsize, ts_hburst, ts_hprot
  );
endinterface

// File: rtl/ahb_default_slv.sv
// Default slave: two-cycle ERROR for active transfers to unmapped space, rdata always zero.
module ahb_default_slv
  import ahb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     accept,
  output ahb_rsp_t rsp
);
  dslv_state_e state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= DS_IDLE;
      rsp.hready <= 1'b1;
      rsp.hresp  <= RESP_OKAY;
      rsp.hrdata <= '0;
    end else begin
      rsp.hrdata <= '0;
      case (state)
        DS_ERR1: begin
          state      <= DS_ERR2;
          rsp.hready <= 1'b1;
          rsp.hresp  <= RESP_ERROR;
        end
        DS_IDLE, DS_ERR2: begin
          if (accept) begin
            state      <= DS_ERR1;
            rsp.hready <= 1'b0;
            rsp.hresp  <= RESP_ERROR;
          end else begin
            state      <= DS_IDLE;
            rsp.hready <= 1'b1;
            rsp.hresp  <= RESP_OKAY;
          end
        end
        default: begin
          state      <= DS_IDLE;
          rsp.hready <= 1'b1;
          rsp.hresp  <= RESP_OKAY;
        end
      endcase
    end
  end
endmodule

// File: rtl/ahblite_1ton.sv
// 1-to-N AHB-Lite decoder: address decode, data-phase response mux, default slave, sticky error capture.
module ahblite_1ton
  import ahb_pkg::*;
#(
  parameter int                     NUM_SLV  = 4,
  parameter logic [NUM_SLV*32-1:0]  SLV_BASE = {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*32-1:0]  SLV_MASK = {4{32'hE000_0000}}
)(
  input  logic              clk,
  input  logic              rst_n,
  ahblite_1ton_if.slave     bus,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [AW-1:0]     err_addr,
  output logic              err_write,
  output logic [SRC_W-1:0]  err_src
);
  logic [NUM_SLV-1:0] hit, sel;
  logic [SRC_W-1:0]   hit_idx, own_idx;
  logic               own_act, dph_write, dflt_acc, cap;
  logic [AW-1:0]      dph_addr;
  ahb_rsp_t           rsp, dflt_rsp;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
    assign hit[gi] = bus.fm_hsel &&
                     (((bus.fm_haddr ^ SLV_BASE[32*gi +: 32]) & SLV_MASK[32*gi +: 32]) == '0);
  end

  // Lowest index wins on overlap; no hit maps to index NUM_SLV (default slave).
  always_comb begin
    sel     = '0;
    hit_idx = SRC_W'(NUM_SLV);
    for (int i = NUM_SLV-1; i >= 0; i--) begin
      if (hit[i]) begin
        sel     = '0;
        sel[i]  = 1'b1;
        hit_idx = SRC_W'(i);
      end
    end
  end

  assign bus.ts_hsel   = sel;
  assign bus.ts_haddr  = bus.fm_haddr;
  assign bus.ts_hwdata = bus.fm_hwdata;
  assign bus.ts_htrans = bus.fm_htrans;
  assign bus.ts_hwrite = bus.fm_hwrite;
  assign bus.ts_hsize  = bus.fm_hsize;
  assign bus.ts_hburst = bus.fm_hburst;
  assign bus.ts_hprot  = bus.fm_hprot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_act   <= 1'b0;
      own_idx   <= '0;
      dph_addr  <= '0;
      dph_write <= 1'b0;
    end else if (rsp.hready) begin
      own_act   <= bus.fm_hsel & trans_active(bus.fm_htrans);
      own_idx   <= hit_idx;
      dph_addr  <= bus.fm_haddr;
      dph_write <= bus.fm_hwrite;
    end
  end

  assign dflt_acc = rsp.hready & bus.fm_hsel & ~|hit & trans_active(bus.fm_htrans);

  ahb_default_slv u_dflt (.clk(clk), .rst_n(rst_n), .accept(dflt_acc), .rsp(dflt_rsp));

  always_comb begin
    rsp.hready = 1'b1;
    rsp.hresp  = RESP_OKAY;
    rsp.hrdata = '0;
    if (own_act) begin
      if (own_idx == SRC_W'(NUM_SLV)) begin
        rsp = dflt_rsp;
      end else begin
        for (int i = 0; i < NUM_SLV; i++) begin
          if (own_idx == SRC_W'(i)) begin
            rsp.hready = bus.fs_hready[i];
            rsp.hresp  = bus.fs_hresp[i];
            rsp.hrdata = bus.fs_hrdata[i];
          end
        end
      end
    end
  end

  assign bus.tm_hready = rsp.hready;
  assign bus.tm_hresp  = rsp.hresp;
  assign bus.tm_hrdata = rsp.hrdata;
  assign bus.ts_hready = {NUM_SLV{rsp.hready}};

  // A clear coinciding with a fresh ERROR re-arms and captures in the same cycle.
  assign cap = rsp.hresp & ~rsp.hready & (~err_valid | err_clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_src   <= '0;
    end else if (cap) begin
      err_valid <= 1'b1;
      err_addr  <= dph_addr;
      err_write <= dph_write;
      err_src   <= own_idx;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
endmodule
